// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - common data bus packet type shared by the FUs, ROB, RAT and reservation stations
package cdb_pkg;

  typedef struct packed {
    logic        cdb_broadcast;
    logic        br_mispred;
    logic [4:0]  cdb_aaddr;
    logic [5:0]  p_addr;
    logic [4:0]  rob_tag;
    logic [31:0] data;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - two-lane CDB arbiter: round-robin for general units,
// lane 2 reserved for the branch unit when it has a result

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = 6,
  parameter int BR_IDX  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  cdb_pkt_t [NUM_REQ-1:0] req_pkt,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   flush,
  output cdb_pkt_t               cdb_pkt,
  output cdb_pkt_t               cdb_pkt2
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] BR_I     = IDX_W'(BR_IDX);
  localparam logic [IDX_W-1:0] FIRST_NB = (BR_IDX == 0) ? IDX_W'(1) : '0;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] next_nb(input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] n;
    n = wrap_inc(i);
    if (n == BR_I) n = wrap_inc(n);
    return n;
  endfunction

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  cdb_pkt_t         lane1_q, lane1_d;
  cdb_pkt_t         lane2_q, lane2_d;

  logic             nb1_vld, nb2_vld;
  logic [IDX_W-1:0] nb1, nb2, idx;
  logic             gnt_en, l1_win, l2_gen, br_win;

  // First two valid general requesters in round-robin order from rr_ptr.
  always_comb begin
    nb1_vld = 1'b0;
    nb2_vld = 1'b0;
    nb1     = '0;
    nb2     = '0;
    idx     = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (idx != BR_I && req_valid[idx]) begin
        if (!nb1_vld) begin
          nb1_vld = 1'b1;
          nb1     = idx;
        end else if (!nb2_vld) begin
          nb2_vld = 1'b1;
          nb2     = idx;
        end
      end
      idx = wrap_inc(idx);
    end
  end

  assign gnt_en = !rst && !flush;
  assign l1_win = gnt_en && nb1_vld;
  assign br_win = gnt_en && req_valid[BR_IDX];
  assign l2_gen = gnt_en && !req_valid[BR_IDX] && nb2_vld;

  always_comb begin
    req_ready = '0;
    lane1_d   = '0;
    lane2_d   = '0;
    rr_ptr_d  = rr_ptr_q;
    if (l1_win) begin
      req_ready[nb1]        = 1'b1;
      lane1_d               = req_pkt[nb1];
      lane1_d.cdb_broadcast = 1'b1;
      lane1_d.br_mispred    = 1'b0;
      rr_ptr_d              = next_nb(l2_gen ? nb2 : nb1);
    end
    // Mispredict recovery only reads lane 2, so only the branch unit may raise it there.
    if (br_win) begin
      req_ready[BR_IDX]     = 1'b1;
      lane2_d               = req_pkt[BR_IDX];
      lane2_d.cdb_broadcast = 1'b1;
    end else if (l2_gen) begin
      req_ready[nb2]        = 1'b1;
      lane2_d               = req_pkt[nb2];
      lane2_d.cdb_broadcast = 1'b1;
      lane2_d.br_mispred    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane1_q  <= '0;
      lane2_q  <= '0;
      rr_ptr_q <= FIRST_NB;
    end else begin
      lane1_q  <= lane1_d;
      lane2_q  <= lane2_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign cdb_pkt  = lane1_q;
  assign cdb_pkt2 = lane2_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [5:0]     req_valid;
  logic [5:0]     req_ready;
  cdb_pkt_t [5:0] req_pkt;
  cdb_pkt_t       cdb_pkt;
  cdb_pkt_t       cdb_pkt2;
  cdb_pkt_t       zpkt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(6), .BR_IDX(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_pkt  (req_pkt),
    .req_ready(req_ready),
    .flush    (flush),
    .cdb_pkt  (cdb_pkt),
    .cdb_pkt2 (cdb_pkt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cdb_pkt_t mk(input int i, input logic mis);
    cdb_pkt_t p;
    p.cdb_broadcast = 1'b0;
    p.br_mispred    = mis;
    p.cdb_aaddr     = 5'(i + 1);
    p.p_addr        = 6'(i + 16);
    p.rob_tag       = 5'(i + 3);
    p.data          = 32'hC0DE_0000 | 32'(i);
    return p;
  endfunction

  function automatic cdb_pkt_t bc(input cdb_pkt_t p, input logic mis);
    cdb_pkt_t r;
    r               = p;
    r.cdb_broadcast = 1'b1;
    r.br_mispred    = mis;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 6; i++) req_pkt[i] = mk(i, 1'b0);
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 6'b111111;

    // reset with every requester valid
    @(negedge clk); #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    chk("rst_lane1", 64'(cdb_pkt), 64'h0);
    chk("rst_lane2", 64'(cdb_pkt2), 64'h0);
    chk("rst_rr", 64'(dut.rr_ptr_q), 64'd0);

    // two general requests
    @(negedge clk);
    rst = 1'b0; req_valid = 6'b000101; #1;
    chk("gen2_ready", 64'(req_ready), 64'b000101);
    @(posedge clk); #1;
    chk("gen2_lane1", 64'(cdb_pkt), 64'(bc(req_pkt[0], 1'b0)));
    chk("gen2_lane2", 64'(cdb_pkt2), 64'(bc(req_pkt[2], 1'b0)));
    chk("gen2_rr", 64'(dut.rr_ptr_q), 64'd3);

    // single grant of 4 wraps rr past the branch index to 0
    @(negedge clk);
    req_valid = 6'b010000; #1;
    chk("wrap_ready", 64'(req_ready), 64'b010000);
    @(posedge clk); #1;
    chk("wrap_lane1", 64'(cdb_pkt), 64'(bc(req_pkt[4], 1'b0)));
    chk("wrap_lane2", 64'(cdb_pkt2), 64'h0);
    chk("wrap_rr", 64'(dut.rr_ptr_q), 64'd0);

    // branch priority on lane 2
    @(negedge clk);
    req_valid = 6'b111010; #1;
    chk("br_ready", 64'(req_ready), 64'b100010);
    @(posedge clk); #1;
    chk("br_lane1", 64'(cdb_pkt), 64'(bc(req_pkt[1], 1'b0)));
    chk("br_lane2", 64'(cdb_pkt2), 64'(bc(req_pkt[5], 1'b0)));
    chk("br_rr", 64'(dut.rr_ptr_q), 64'd2);

    // pending 3 and 4 then drain
    @(negedge clk);
    req_valid = 6'b011000; #1;
    chk("pend_ready", 64'(req_ready), 64'b011000);
    @(posedge clk); #1;
    chk("pend_lane1", 64'(cdb_pkt), 64'(bc(req_pkt[3], 1'b0)));
    chk("pend_lane2", 64'(cdb_pkt2), 64'(bc(req_pkt[4], 1'b0)));
    chk("pend_rr", 64'(dut.rr_ptr_q), 64'd0);

    // fairness: 0-4 held valid for three cycles
    @(negedge clk);
    req_valid = 6'b011111; #1;
    chk("fair1_ready", 64'(req_ready), 64'b000011);
    @(posedge clk); #1;
    chk("fair1_lane1", 64'(cdb_pkt), 64'(bc(req_pkt[0], 1'b0)));
    chk("fair1_lane2", 64'(cdb_pkt2), 64'(bc(req_pkt[1], 1'b0)));
    chk("fair1_rr", 64'(dut.rr_ptr_q), 64'd2);
    @(negedge clk); #1;
    chk("fair2_ready", 64'(req_ready), 64'b001100);
    @(posedge clk); #1;
    chk("fair2_lane1", 64'(cdb_pkt), 64'(bc(req_pkt[2], 1'b0)));
    chk("fair2_lane2", 64'(cdb_pkt2), 64'(bc(req_pkt[3], 1'b0)));
    chk("fair2_rr", 64'(dut.rr_ptr_q), 64'd4);
    @(negedge clk); #1;
    chk("fair3_ready", 64'(req_ready), 64'b010001);
    @(posedge clk); #1;
    chk("fair3_lane1", 64'(cdb_pkt), 64'(bc(req_pkt[4], 1'b0)));
    chk("fair3_lane2", 64'(cdb_pkt2), 64'(bc(req_pkt[0], 1'b0)));
    chk("fair3_rr", 64'(dut.rr_ptr_q), 64'd1);

    // branch mispredict alone
    @(negedge clk);
    req_pkt[5] = mk(5, 1'b1);
    req_valid  = 6'b100000; #1;
    chk("mis_ready", 64'(req_ready), 64'b100000);
    @(posedge clk); #1;
    chk("mis_lane2", 64'(cdb_pkt2), 64'(bc(req_pkt[5], 1'b1)));
    chk("mis_lane2_flag", 64'(cdb_pkt2.br_mispred), 64'd1);
    chk("mis_lane1", 64'(cdb_pkt), 64'h0);
    chk("mis_rr", 64'(dut.rr_ptr_q), 64'd1);

    // general unit claiming mispredict, zero addresses
    @(negedge clk);
    zpkt           = mk(0, 1'b1);
    zpkt.cdb_aaddr = 5'd0;
    zpkt.p_addr    = 6'd0;
    req_pkt[0]     = zpkt;
    req_valid      = 6'b000001; #1;
    chk("gmis_ready", 64'(req_ready), 64'b000001);
    @(posedge clk); #1;
    chk("gmis_lane1", 64'(cdb_pkt), 64'(bc(zpkt, 1'b0)));
    chk("gmis_lane1_flag", 64'(cdb_pkt.br_mispred), 64'd0);
    chk("gmis_lane2", 64'(cdb_pkt2), 64'h0);
    chk("gmis_rr", 64'(dut.rr_ptr_q), 64'd1);

    // flush blocks grants
    @(negedge clk);
    req_pkt[0] = mk(0, 1'b0);
    flush      = 1'b1;
    req_valid  = 6'b100101; #1;
    chk("flush_ready", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    chk("flush_lane1", 64'(cdb_pkt), 64'h0);
    chk("flush_lane2", 64'(cdb_pkt2), 64'h0);
    chk("flush_rr", 64'(dut.rr_ptr_q), 64'd1);

    // first cycle after flush
    @(negedge clk);
    flush = 1'b0; #1;
    chk("postf_ready", 64'(req_ready), 64'b100100);
    @(posedge clk); #1;
    chk("postf_lane1", 64'(cdb_pkt), 64'(bc(req_pkt[2], 1'b0)));
    chk("postf_lane2", 64'(cdb_pkt2), 64'(bc(req_pkt[5], 1'b1)));
    chk("postf_rr", 64'(dut.rr_ptr_q), 64'd3);

    // leftover request 0
    @(negedge clk);
    req_valid = 6'b000001; #1;
    chk("left_ready", 64'(req_ready), 64'b000001);
    @(posedge clk); #1;
    chk("left_lane1", 64'(cdb_pkt), 64'(bc(req_pkt[0], 1'b0)));
    chk("left_lane2", 64'(cdb_pkt2), 64'h0);
    chk("left_rr", 64'(dut.rr_ptr_q), 64'd1);

    // reset mid-stream
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 6'b001110; #1;
    chk("mrst_ready", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    chk("mrst_lane1", 64'(cdb_pkt), 64'h0);
    chk("mrst_lane2", 64'(cdb_pkt2), 64'h0);
    chk("mrst_rr", 64'(dut.rr_ptr_q), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
